fp_add_sequencer: RTL and testbench

- Multi-cycle controller/datapath sequencer for 32-bit single-precision add/sub.
- Steps one shared mantissa adder through the stages in order: exponent compare/swap, iterative alignment, mantissa add/sub, iterative normalize.
- Sits between the top-level FPU request interface and the mantissa add logic.
- Single operation in flight; start/busy/done handshake.

---
 rtl/fp_add_sequencer.sv | 142 ++++++++++++++
 tb/tb_fp_add_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle single-precision add/sub sequencer (compare, align, add, normalize).
// Define FP_ADD_SEQ_FAST_ALIGN_EN for single-cycle barrel-shift align and LZC normalize.
module fp_add_sequencer #(
  parameter int EXP_WIDTH  = 8,
  parameter int MENT_WIDTH = 23
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic                          opcode_in,
  input  logic [EXP_WIDTH+MENT_WIDTH:0] operand_a_in,
  input  logic [EXP_WIDTH+MENT_WIDTH:0] operand_b_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [EXP_WIDTH+MENT_WIDTH:0] result_out,
  output logic                          overflow_out
);
  localparam int TOP = EXP_WIDTH + MENT_WIDTH;
  localparam int SW = MENT_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0] EMAX = '1;
  typedef enum logic [2:0] {IDLE, COMPARE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state;
  logic [TOP:0] a, b;
  logic op, sub, sign;
  logic [SW-1:0] sig1, sig2, sum, n_sum;
  logic [EXP_WIDTH-1:0] exp, d, n_exp, e1, e2, dd;
  logic [TOP-1:0] ma, mb, mbig, msml;
  logic a_ge, n_fin, n_ovf, n_zero;
  logic [TOP:0] n_res;
  assign ma = a[TOP-1:0];
  assign mb = b[TOP-1:0];
  assign a_ge = ma >= mb;
  assign mbig = a_ge ? ma : mb;
  assign msml = a_ge ? mb : ma;
  assign e1 = mbig[TOP-1:MENT_WIDTH];
  assign e2 = msml[TOP-1:MENT_WIDTH];
  assign dd = e1 - e2;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  logic [EXP_WIDTH-1:0] lz;
  // leading-zero count below the hidden bit position; the highest set bit wins
  always_comb begin
    lz = '0;
    for (int i = 0; i <= MENT_WIDTH; i++) if (sum[i]) lz = EXP_WIDTH'(MENT_WIDTH - i);
  end
`endif
  // next normalize step: carry shift, zero detect, or left shift with underflow flush
  always_comb begin
    n_sum = sum;
    n_exp = exp;
    n_fin = 1'b1;
    n_ovf = 1'b0;
    n_zero = sum == '0;
    if (sum[SW-1]) begin
      n_sum = sum >> 1;
      n_exp = exp + 1'b1;
      n_ovf = exp == EMAX - 1'b1;
    end else if (!n_zero && !sum[MENT_WIDTH]) begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
      n_sum = sum << lz;
      n_exp = exp - lz;
      n_zero = lz >= exp;
`else
      n_sum = sum << 1;
      n_exp = exp - 1'b1;
      n_zero = exp <= EXP_WIDTH'(1);
      n_fin = n_zero | sum[MENT_WIDTH-1];
`endif
    end
  end
  assign n_res = n_zero ? {sign & |sum, {TOP{1'b0}}}
               : n_ovf ? {sign, EMAX, {MENT_WIDTH{1'b0}}}
               : {sign, n_exp, n_sum[MENT_WIDTH-1:0]};
  // sequencer FSM with registered handshake and result
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      result_out <= '0;
      overflow_out <= 1'b0;
      a <= '0;
      b <= '0;
      op <= 1'b0;
      sub <= 1'b0;
      sign <= 1'b0;
      sig1 <= '0;
      sig2 <= '0;
      sum <= '0;
      exp <= '0;
      d <= '0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          a <= operand_a_in;
          b <= operand_b_in;
          op <= opcode_in;
          busy_out <= 1'b1;
          state <= COMPARE;
        end
        COMPARE: begin
          sig1 <= {1'b0, |e1, mbig[MENT_WIDTH-1:0]};
          sig2 <= {1'b0, |e2, msml[MENT_WIDTH-1:0]};
          exp <= e1;
          d <= dd > EXP_WIDTH'(SW) ? EXP_WIDTH'(SW) : dd;
          sub <= op ^ a[TOP] ^ b[TOP];
          sign <= a_ge ? a[TOP] : b[TOP] ^ op;
          state <= ALIGN;
        end
        ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
          sig2 <= sig2 >> d;
          state <= ADD;
`else
          sig2 <= d > EXP_WIDTH'(MENT_WIDTH + 1) ? '0 : d == '0 ? sig2 : sig2 >> 1;
          d <= d == '0 ? d : d - 1'b1;
          state <= d <= EXP_WIDTH'(1) ? ADD : ALIGN;
`endif
        end
        ADD: begin
          sum <= sub ? sig1 - sig2 : sig1 + sig2;
          state <= NORM;
        end
        NORM: begin
          sum <= n_sum;
          exp <= n_exp;
          if (n_fin) begin
            result_out <= n_res;
            overflow_out <= n_ovf;
            done_out <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed add/sub vectors with latency, overflow, ignored-start and reset checks.
module tb_fp_add_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, opcode = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy_out, done_out, overflow_out;
  logic [31:0] result_out;
  int total = 0, bad = 0;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  fp_add_sequencer dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .opcode_in(opcode),
    .operand_a_in(a), .operand_b_in(b), .busy_out(busy_out), .done_out(done_out),
    .result_out(result_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, busy_out, 0);
    check({tag, ".done"}, done_out, 0);
    check({tag, ".result"}, result_out, 0);
    check({tag, ".ovf"}, overflow_out, 0);
  endtask

  // poke > 0 pulses a second start with other operands after edge poke
  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                        input logic op, input logic [31:0] er, input logic eo,
                        input int el, input int poke);
    int lat = 0;
    int extra = 0;
    logic busy_ok = 1'b1;
    @(negedge clk);
    a = oa;
    b = ob;
    opcode = op;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (poke == i) begin
        start = 1'b1;
        a = 32'h40400000;
        b = 32'h3F000000;
        opcode = 1'b0;
      end else if (poke == i - 1) start = 1'b0;
      if (!busy_out) busy_ok = 1'b0;
      if (done_out) lat = i;
    end
    check({tag, ".lat"}, lat, el);
    check({tag, ".result"}, result_out, er);
    check({tag, ".ovf"}, overflow_out, eo);
    check({tag, ".busy_held"}, busy_ok, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (done_out) extra++;
      if (i == 0) check({tag, ".busy_drop"}, busy_out, 0);
    end
    check({tag, ".extra_done"}, extra, 0);
    check({tag, ".result_hold"}, result_out, er);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4, 0);
    run_op("three_plus_half", 32'h40400000, 32'h3F000000, 1'b0, 32'h40600000, 1'b0, FAST ? 4 : 5, 0);
    run_op("sub_1p5_1", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 4, 0);
    run_op("sub_equal", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 4, 0);
    run_op("one_plus_eighth", 32'h3F800000, 32'h3E000000, 1'b0, 32'h3F900000, 1'b0, FAST ? 4 : 6, 0);
    run_op("one_minus_7_8", 32'h3F800000, 32'h3F600000, 1'b1, 32'h3E000000, 1'b0, FAST ? 4 : 6, 0);
    run_op("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 4, 0);
    run_op("one_plus_neg_half", 32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 1'b0, 4, 0);
    run_op("zero_plus_one", 32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, FAST ? 4 : 28, 0);
    run_op("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4, 0);
    run_op("ovf_clear", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4, 0);
    run_op("ignored_start", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4, 2);
    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3F000000;
    opcode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("abort");
    repeat (2) @(negedge clk);
    check_idle("abort_hold");
    rst_n = 1'b1;
    run_op("after_abort", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
